// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add unsigned multiplier with a start/busy/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_shift_add #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [2*WIDTH-1:0] product_reg, product_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  // Datapath for one RUN step; the single adder is shared by every step.
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_shift;
  logic [CNT_W-1:0]   cnt_step;
  logic               last_step;

  assign acc_step     = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign mplier_shift = mplier_reg >> 1;
  assign cnt_step     = cnt_reg + CNT_W'(1);

`ifdef SEQ_MULT_EARLY_TERM_EN
  // No set bits left in the multiplier means every further step adds nothing.
  assign last_step = (cnt_step == CNT_W'(WIDTH)) || (mplier_shift == '0);
`else
  assign last_step = (cnt_step == CNT_W'(WIDTH));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          acc_next    = '0;
          mcand_next  = {{WIDTH{1'b0}}, a};
          mplier_next = b;
          cnt_next    = '0;
          state_next  = RUN;
        end else begin
          state_next  = IDLE;
        end
      end
      RUN: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_shift;
        cnt_next    = cnt_step;
        if (last_step) begin
          product_next = acc_step;
          state_next   = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add at WIDTH=4 and WIDTH=8.
module tb_seq_mult_shift_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  logic        sel8 = 1'b0;
  logic        cur_busy, cur_done;
  logic [15:0] cur_prod;

  seq_mult_shift_add #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  seq_mult_shift_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  always #5 clk = ~clk;

  always_comb begin
    cur_busy = sel8 ? busy8 : busy4;
    cur_done = sel8 ? done8 : done4;
    cur_prod = sel8 ? prod8 : {8'd0, prod4};
  end

  typedef struct {
    bit w8;
    int a;
    int b;
    int prod;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: number of RUN steps for an operation, from the multiplier value alone.
  function automatic int exp_steps(input int w, input int b);
    int s;
`ifdef SEQ_MULT_EARLY_TERM_EN
    s = 1;
    for (int i = 0; i < w; i++)
      if (b[i]) s = i + 1;
`else
    s = w;
`endif
    return s;
  endfunction

  // Counts edges until done is seen; product must hold and busy stay high meanwhile.
  task automatic wait_done(input string name, output int k);
    bit got;
    logic [15:0] held;
    got  = 1'b0;
    held = cur_prod;
    k    = 0;
    while (!got && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (cur_done) got = 1'b1;
      else begin
        check({name, " busy"}, cur_busy, 1);
        check({name, " hold"}, cur_prod, held);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_done required=done", name);
    end else begin
      check({name, " busy_at_done"}, cur_busy, 0);
    end
  endtask

  task automatic launch(input bit w8, input int a, input int b);
    @(negedge clk);
    sel8 = w8;
    if (w8) begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input bit w8, input int a, input int b, input int expp, input string name);
    int k;
    int w;
    w = w8 ? 8 : 4;
    launch(w8, a, b);
    start4 = 1'b0;
    start8 = 1'b0;
    wait_done(name, k);
    $display("op %s w=%0d a=%0d b=%0d product=%0d cycles=%0d", name, w, a, b, cur_prod, k + 1);
    check({name, " product"}, cur_prod, expp);
    check({name, " latency"}, k + 1, exp_steps(w, b) + 1);
    @(posedge clk); #1;
    check({name, " done_drop"}, cur_done, 0);
    check({name, " idle_busy"}, cur_busy, 0);
    check({name, " held"}, cur_prod, expp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{0, 3, 5, 15};
    vecs[1] = '{0, 15, 15, 225};
    vecs[2] = '{0, 0, 9, 0};
    vecs[3] = '{0, 9, 0, 0};
    vecs[4] = '{0, 15, 1, 15};
    vecs[5] = '{0, 8, 8, 64};
    vecs[6] = '{1, 255, 255, 65025};
    vecs[7] = '{1, 200, 1, 200};
    vecs[8] = '{1, 10, 128, 1280};
    vecs[9] = '{1, 1, 0, 0};

    // Reset state
    #12;
    check("rst busy4", busy4, 0);
    check("rst done4", done4, 0);
    check("rst prod4", prod4, 0);
    check("rst busy8", busy8, 0);
    check("rst prod8", prod8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].w8, vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));

    // Start held during RUN is ignored; accepted once DONE is reached
    launch(0, 9, 0);
    a4 = 4'd2;
    b4 = 4'd2;
    wait_done("ign_first", k);
    $display("op ign_first a=9 b=0 product=%0d cycles=%0d", prod4, k + 1);
    check("ign_first product", prod4, 0);
    check("ign_first latency", k + 1, exp_steps(4, 0) + 1);
    @(posedge clk); #1;
    start4 = 1'b0;
    check("ign_restart busy", busy4, 1);
    check("ign_restart done", done4, 0);
    wait_done("ign_second", k);
    $display("op ign_second a=2 b=2 product=%0d cycles=%0d", prod4, k + 1);
    check("ign_second product", prod4, 4);
    check("ign_second latency", k + 1, exp_steps(4, 2) + 1);
    @(posedge clk); #1;

    // Back-to-back with start held high
    launch(0, 1, 3);
    for (int i = 1; i <= 5; i++) begin
      wait_done($sformatf("b2b%0d", i), k);
      $display("op b2b%0d a=%0d b=3 product=%0d spacing=%0d", i, i, prod4, k);
      check($sformatf("b2b%0d product", i), prod4, i * 3);
      if (i == 1) check("b2b1 latency", k + 1, exp_steps(4, 3) + 1);
      else        check($sformatf("b2b%0d spacing", i), k, exp_steps(4, 3) + 1);
      if (i < 5) a4 = 4'(i + 1);
      else       start4 = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b idle", busy4, 0);

    // Asynchronous reset in the middle of an operation
    launch(0, 7, 6);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("op midreset busy=%0d done=%0d product=%0d", busy4, done4, prod4);
    check("midrst busy", busy4, 0);
    check("midrst done", done4, 0);
    check("midrst product", prod4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 2, 3, 6, "after_rst");

    // Randomised operands against plain arithmetic
    for (int i = 0; i < 16; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255) >> $urandom_range(0, 7));
      run_op(1, ra, rb, ra * rb, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      run_op(0, ra, rb, ra * rb, $sformatf("rnd4_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
